// File: rtl/systolic_result_drain.sv
// Rebuilds the diagonally skewed result wavefront of systolic_array into a row-major
// buffer, then streams it out one full row per beat on a valid/ready interface.
module systolic_result_drain #(
  parameter int MAX_N  = 32,
  parameter int DATA_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [$clog2(MAX_N+1)-1:0]     matrix_N,
  input  logic [MAX_N*DATA_W-1:0]        P,
  input  logic                           arr_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MAX_N*DATA_W-1:0]        out_row,
  output logic [$clog2(MAX_N)-1:0]       out_row_idx,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           err_overrun
);

  localparam int IW = $clog2(MAX_N);
  localparam int NW = $clog2(MAX_N + 1);
  localparam int KW = NW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              arr_ready_q;
  logic [NW-1:0]     n_q, n_d;
  logic [KW-1:0]     k_q, k_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] row_buf_q [MAX_N][MAX_N];

  logic              rise;
  logic              start;
  logic [NW-1:0]     n_clamp;
  logic [NW-1:0]     n_eff;
  logic [KW-1:0]     k_eff;
  logic              cap_active;
  logic              cap_last;
  logic              ptr_last;
  logic              xfer;
  logic [MAX_N-1:0]  wr_en;
  logic [IW-1:0]     wr_row [MAX_N];

  // Control decode. The start cycle is handled as result cycle k=0 using the
  // freshly clamped N, so lane 0 is captured on the very edge that sees the rise.
  always_comb begin
    rise       = arr_ready && !arr_ready_q;
    start      = rise && en && (state_q == S_IDLE);
    n_clamp    = (matrix_N > NW'(MAX_N)) ? NW'(MAX_N) : matrix_N;
    n_eff      = (state_q == S_IDLE) ? n_clamp : n_q;
    k_eff      = (state_q == S_IDLE) ? '0 : k_q;
    cap_active = (state_q == S_CAPTURE) || (start && (n_clamp != '0));
    cap_last   = cap_active && (k_eff == (({1'b0, n_eff} << 1) - KW'(2)));
    ptr_last   = ((NW'(ptr_q) + NW'(1)) == n_q);
    xfer       = (state_q == S_DRAIN) && out_ready;
  end

  // Lane j at cycle k carries row k-j; only in-range diagonal entries are written.
  always_comb begin
    // NOTE: every comb output gets a default before any condition, so no latch is inferred.
    for (int j = 0; j < MAX_N; j++) begin
      wr_en[j]  = 1'b0;
      wr_row[j] = '0;
      if (cap_active && (NW'(j) < n_eff) && (KW'(j) <= k_eff) &&
          ((k_eff - KW'(j)) < KW'(n_eff))) begin
        wr_en[j]  = 1'b1;
        wr_row[j] = IW'(k_eff - KW'(j));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (n_clamp != '0)) begin
          state_d = cap_last ? S_DRAIN : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cap_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer && ptr_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_DRAIN);
    busy      = (state_q != S_IDLE);
    out_last  = out_valid && ptr_last;
    out_row   = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (out_valid && (NW'(j) < n_q)) begin
        out_row[j*DATA_W +: DATA_W] = row_buf_q[ptr_q][j];
      end
    end
  end

  assign out_row_idx = ptr_q;
  assign done        = done_q;
  assign err_overrun = err_q;

  always_comb begin
    n_d    = start ? n_clamp : n_q;
    k_d    = (cap_active && !cap_last) ? (k_eff + KW'(1)) : '0;
    ptr_d  = ptr_q;
    if (xfer) begin
      ptr_d = ptr_last ? '0 : (ptr_q + IW'(1));
    end
    done_d = (start && (n_clamp == '0)) || (xfer && ptr_last);
    // A rise while busy is recorded but otherwise ignored; the running matrix is untouched.
    err_d  = err_q || (rise && (state_q != S_IDLE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_ready_q <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      ptr_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      arr_ready_q <= arr_ready;
      n_q         <= n_d;
      k_q         <= k_d;
      ptr_q       <= ptr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the row buffer is a flop array, not a RAM, so it can and must clear on reset.
      for (int r = 0; r < MAX_N; r++) begin
        for (int j = 0; j < MAX_N; j++) begin
          row_buf_q[r][j] <= '0;
        end
      end
    end else begin
      for (int j = 0; j < MAX_N; j++) begin
        if (wr_en[j]) begin
          row_buf_q[wr_row[j]][j] <= P[j*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Collects the diagonally skewed result wavefront leaving `systolic_array` on its `P` lanes and rebuilds it into row-major order. It then streams the result matrix out one full row per beat on a valid/ready interface. It is the read-side counterpart of the skewed operand feed into the array. It sits between `systolic_array` and the result write-back path.

Parameters:
- MAX_N, 32, max matrix dimension and number of `P` lanes
- DATA_W, 16, lane width (fp16 bit pattern, passed through untouched)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  block enable; a capture can only start while high
- matrix_N  in  6  matrix dimension N; latched at capture start
- P  in  [0:MAX_N-1] x DATA_W  skewed result lanes from `systolic_array`
- arr_ready  in  1  `systolic_array` `ready`; its rising edge marks result cycle k=0
- out_valid  out  1  `out_row` holds a valid row
- out_ready  in  1  downstream accepts the row
- out_row  out  [0:MAX_N-1] x DATA_W  row data; lanes >= N read 0
- out_row_idx  out  5  row index r of `out_row`
- out_last  out  1  high with `out_valid` on row N-1
- busy  out  1  high in CAPTURE or DRAIN
- done  out  1  one-cycle pulse after the last row is accepted
- err_overrun  out  1  sticky: an `arr_ready` rising edge arrived while busy

Behaviour:
- Reset (async, active-low):
  - state IDLE; all counters 0; row buffer cleared to 0.
  - `out_valid`, `out_last`, `busy`, `done`, `err_overrun` = 0; `out_row` = 0; `out_row_idx` = 0.
- Skew contract: at result cycle k (k=0 is the first cycle `arr_ready` is sampled high), lane j carries C[r][j] with r = k - j, valid only when 0 <= r < N. The full matrix arrives over cycles 0..2N-2.
- Edge detect: `arr_ready` is registered; a rise is `arr_ready` high while the registered copy is low.
- N handling, decided at capture start:
  - N latched from `matrix_N`; values > MAX_N clamp to MAX_N.
  - N = 0: no capture; `done` pulses the next cycle; state stays IDLE.
- IDLE:
  - On a rise with `en` = 1, latch N and go to CAPTURE.
  - The cycle-0 lane data is written in that same cycle (lane 0 -> buf[0][0]).
  - k counter = 1 next.
- CAPTURE:
  - Each cycle, for each j < N with 0 <= k-j < N: buf[k-j][j] <= P[j]. All other lanes are ignored.
  - After k = 2N-2 is written, go to DRAIN with row pointer = 0.
  - `en` dropping mid-capture has no effect.
  - Latency from rise to first `out_valid` = 2N-1 cycles (N=4: 7 cycles).
- DRAIN:
  - `out_valid` = 1; `out_row` = buf[ptr] (lanes >= N forced to 0); `out_row_idx` = ptr; `out_last` = (ptr == N-1).
  - Transfer happens on `out_valid` && `out_ready`; ptr increments.
  - `out_row` and `out_row_idx` stay stable while `out_valid` && !`out_ready`.
  - Transfer of the last row: go to IDLE and pulse `done` for one cycle; `out_valid` falls the same edge.
  - With `out_ready` held high, one row per cycle.
- Overrun: a rise during CAPTURE or DRAIN sets `err_overrun`, which only reset clears. The current operation continues unaffected; the new result is dropped.
- A rise arriving in the same cycle `done` pulses is a valid new start from IDLE.
- Reset mid-operation aborts immediately: buffer cleared, no `done`.
- Storage: MAX_N x MAX_N x DATA_W register array.
- The block performs no arithmetic; data is bit-exact.

Test Plan:
1. N=4 directed: drive rise, then at cycle k lane j = 16'h0r0j with r=k-j (other lanes 16'hFFFF), `out_ready`=1.
   -> Rows r=0..3 each read {0r00,0r01,0r02,0r03}, lanes 4..31 = 0.
   -> First `out_valid` 7 cycles after the rise; `out_last` on r=3; `done` once.
2. Backpressure: as test 1, but `out_ready` toggles 1,0,0,1,...
   -> Row data and index stable while stalled; exactly 4 transfers in order 0..3.
3. N=1 and N=32:
   -> N=1: one capture cycle, a single row with `out_last`.
   -> N=32: 63 capture cycles, 32 rows, every element matches its 16'h(r<<8 | j) tag.
4. Boundaries:
   -> `matrix_N`=0 gives a `done` pulse, no `out_valid`.
   -> `matrix_N`=40 behaves exactly as 32.
   -> `en`=0 at the rise: no capture, stays IDLE.
5. Overrun: second `arr_ready` rise during DRAIN.
   -> `err_overrun`=1 and stays 1; the first matrix still drains correctly.
   -> Back-to-back rise on the `done` cycle starts a new capture.
6. Reset mid-CAPTURE at k=3 (N=4):
   -> All outputs 0 asynchronously, no `done`.
   -> A following clean run reproduces the test 1 result.
